lz77_decoder: RTL and testbench

LZ77_DECODER -- requirements
Module: lz77_decoder

---
 rtl/lz77_decoder.sv | 176 +++++++++++++++++
 tb/tb_lz77_decoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_decoder.sv
// lz77_decoder
//   Decodes LZ77 code triples (offset, match_len, char_nxt) into a stream of
//   characters. Each accepted code emits match_len characters copied from a
//   9-entry search buffer, followed by the literal char_nxt. A literal of '$'
//   (8'h24) ends the stream: the decoder parks in DONE until reset.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active low
//   valid      in   code triple present on offset/match_len/char_nxt
//   offset     in   [3:0] copy distance, 0 = newest char, 8 = oldest, 9..15 reserved
//   match_len  in   [2:0] number of chars to copy (0..7)
//   char_nxt   in   [7:0] literal emitted after the copied chars
//   ready      out  decoder accepts a code this cycle (IDLE only)
//   char_out   out  [7:0] decoded character, registered
//   out_valid  out  char_out holds a new character this cycle, registered
//   finish     out  end marker decoded, sticky until reset
//
// State table
//   state | meaning
//   IDLE  | waiting for a code; ready=1
//   COPY  | emitting one copied char per cycle from sbuf[offset_q]
//   LIT   | emitting the latched literal char_nxt_q
//   DONE  | '$' literal emitted; outputs quiet, finish held, exit only by reset

module lz77_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [3:0] offset,
  input  logic [2:0] match_len,
  input  logic [7:0] char_nxt,
  output logic       ready,
  output logic [7:0] char_out,
  output logic       out_valid,
  output logic       finish
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    LIT  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] END_CHAR   = 8'h24;
  localparam logic [7:0] EMPTY_CHAR = 8'hFF;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] offset_q;
  logic [2:0] remain_q;
  logic [7:0] char_nxt_q;
  logic [7:0] sbuf [0:8];

  logic       accept;
  logic       shift_en;
  logic [7:0] shift_char;
  logic [7:0] copy_char;

  assign accept = ready && valid;

  // Reserved offsets read as an empty buffer slot.
  always_comb begin
    copy_char = EMPTY_CHAR;
    if (offset_q <= 4'd8) begin
      copy_char = sbuf[offset_q];
    end
  end

  // Every emitted character, copied or literal, becomes the newest buffer entry.
  always_comb begin
    shift_en   = 1'b0;
    shift_char = copy_char;
    if (state == COPY) begin
      shift_en   = 1'b1;
      shift_char = copy_char;
    end else if (state == LIT) begin
      shift_en   = 1'b1;
      shift_char = char_nxt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (valid) begin
          state_nxt = (match_len != 3'd0) ? COPY : LIT;
        end
      end
      COPY: begin
        // remain_q is at least 1 whenever COPY is entered.
        if (remain_q == 3'd1) begin
          state_nxt = LIT;
        end
      end
      LIT: begin
        state_nxt = (char_nxt_q == END_CHAR) ? DONE : IDLE;
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset_q   <= 4'd0;
      remain_q   <= 3'd0;
      char_nxt_q <= 8'h00;
    end else if (accept) begin
      offset_q   <= offset;
      remain_q   <= match_len;
      char_nxt_q <= char_nxt;
    end else if (state == COPY) begin
      remain_q   <= remain_q - 3'd1;
    end
  end

  // Offset stays fixed across a match while the buffer shifts underneath it,
  // so a match longer than its distance replays the repeating pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) begin
        sbuf[i] <= EMPTY_CHAR;
      end
    end else if (shift_en) begin
      for (int i = 8; i > 0; i--) begin
        sbuf[i] <= sbuf[i-1];
      end
      sbuf[0] <= shift_char;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_out  <= 8'h00;
      out_valid <= 1'b0;
      finish    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        COPY: begin
          char_out  <= copy_char;
          out_valid <= 1'b1;
        end
        LIT: begin
          char_out  <= char_nxt_q;
          out_valid <= 1'b1;
          // Only the literal terminates; a '$' arriving through COPY is data.
          if (char_nxt_q == END_CHAR) begin
            finish <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_decoder.sv
module tb_lz77_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] offset = 4'd0;
  logic [2:0] match_len = 3'd0;
  logic [7:0] char_nxt = 8'h00;
  logic       ready;
  logic [7:0] char_out;
  logic       out_valid;
  logic       finish;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q [$];

  always #5 clk = ~clk;

  lz77_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .offset    (offset),
    .match_len (match_len),
    .char_nxt  (char_nxt),
    .ready     (ready),
    .char_out  (char_out),
    .out_valid (out_valid),
    .finish    (finish)
  );

  // Output collector, sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) got_q.push_back(char_out);
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout got ready=%b exp 1", tag, ready);
    end
  endtask

  task automatic send_code(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
    @(negedge clk);
    wait_ready("send_code");
    valid = 1'b1; offset = o; match_len = l; char_nxt = c;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (char_out !== 8'h00) begin errors++; $display("FAIL reset_char_out got %h exp 00", char_out); end
    checks++;
    if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b exp 0", finish); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", ready); end
  endtask

  task automatic test_single_literal;
    apply_reset();
    got_q.delete();
    @(negedge clk);
    valid = 1'b1; offset = 4'd0; match_len = 3'd0; char_nxt = 8'h61;
    @(posedge clk);
    #1;
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_accept_cycle got ready=%b out_valid=%b exp 0 0", ready, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || char_out !== 8'h61) begin
      errors++; $display("FAIL single_output got out_valid=%b char=%h exp 1 61", out_valid, char_out);
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_back got %b exp 1", ready); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || char_out !== 8'h61) begin
      errors++; $display("FAIL single_hold got out_valid=%b char=%h exp 0 61", out_valid, char_out);
    end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", got_q.size()); end
  endtask

  task automatic test_overlap;
    logic [7:0] exp_s [7];
    exp_s = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h62, 8'h63};
    apply_reset();
    got_q.delete();
    send_code(4'd0, 3'd0, 8'h61);
    send_code(4'd0, 3'd0, 8'h62);
    send_code(4'd1, 3'd4, 8'h63);
    wait_ready("overlap");
    @(negedge clk);
    checks++;
    if (got_q.size() != 7) begin errors++; $display("FAIL overlap_count got %0d exp 7", got_q.size()); end
    for (int i = 0; i < 7; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++;
      if (g !== exp_s[i]) begin errors++; $display("FAIL overlap_char[%0d] got %h exp %h", i, g, exp_s[i]); end
    end
  endtask

  task automatic test_initial_copy;
    logic [7:0] exp_s [4];
    exp_s = '{8'hFF, 8'hFF, 8'hFF, 8'h78};
    apply_reset();
    got_q.delete();
    send_code(4'd0, 3'd3, 8'h78);
    wait_ready("initial_copy");
    @(negedge clk);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL init_copy_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++;
      if (g !== exp_s[i]) begin errors++; $display("FAIL init_copy_char[%0d] got %h exp %h", i, g, exp_s[i]); end
    end
  endtask

  task automatic test_valid_ignored;
    logic [7:0] exp_s [7];
    exp_s = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h62, 8'h63};
    apply_reset();
    got_q.delete();
    send_code(4'd0, 3'd0, 8'h61);
    send_code(4'd0, 3'd0, 8'h62);
    wait_ready("ignored_pre");
    valid = 1'b1; offset = 4'd1; match_len = 3'd4; char_nxt = 8'h63;
    // Four COPY cycles plus the LIT cycle with valid held high and a new triple.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL ignored_busy_ready[%0d] got %b exp 0", i, ready); end
      valid = 1'b1; offset = 4'd0; match_len = 3'd7; char_nxt = 8'h40 + 8'(i);
    end
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ignored_ready_after_len_plus_2 got %b exp 1", ready); end
    @(negedge clk);
    checks++;
    if (got_q.size() != 7) begin errors++; $display("FAIL ignored_count got %0d exp 7", got_q.size()); end
    for (int i = 0; i < 7; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++;
      if (g !== exp_s[i]) begin errors++; $display("FAIL ignored_char[%0d] got %h exp %h", i, g, exp_s[i]); end
    end
  endtask

  task automatic test_end_marker;
    logic [7:0] exp_s [6];
    exp_s = '{8'h70, 8'h71, 8'h72, 8'h70, 8'h71, 8'h24};
    apply_reset();
    got_q.delete();
    send_code(4'd0, 3'd0, 8'h70);
    send_code(4'd0, 3'd0, 8'h71);
    send_code(4'd0, 3'd0, 8'h72);
    send_code(4'd2, 3'd2, 8'h24);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || char_out !== 8'h70 || finish !== 1'b0) begin
      errors++; $display("FAIL end_copy1 got v=%b c=%h f=%b exp 1 70 0", out_valid, char_out, finish);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || char_out !== 8'h71 || finish !== 1'b0) begin
      errors++; $display("FAIL end_copy2 got v=%b c=%h f=%b exp 1 71 0", out_valid, char_out, finish);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || char_out !== 8'h24 || finish !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL end_marker got v=%b c=%h f=%b r=%b exp 1 24 1 0", out_valid, char_out, finish, ready);
    end
    valid = 1'b1; offset = 4'd0; match_len = 3'd0; char_nxt = 8'h6B;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || out_valid !== 1'b0 || finish !== 1'b1) begin
        errors++; $display("FAIL end_done[%0d] got r=%b v=%b f=%b exp 0 0 1", i, ready, out_valid, finish);
      end
    end
    valid = 1'b0;
    checks++;
    if (got_q.size() != 6) begin errors++; $display("FAIL end_count got %0d exp 6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++;
      if (g !== exp_s[i]) begin errors++; $display("FAIL end_char[%0d] got %h exp %h", i, g, exp_s[i]); end
    end
  endtask

  task automatic test_reset_mid_copy;
    apply_reset();
    got_q.delete();
    send_code(4'd0, 3'd0, 8'h67);
    send_code(4'd0, 3'd7, 8'h6D);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ready !== 1'b1 || char_out !== 8'h00 || finish !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got v=%b r=%b c=%h f=%b exp 0 1 00 0", out_valid, ready, char_out, finish);
    end
    got_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL midreset_no_chars got %0d exp 0", got_q.size()); end
    send_code(4'd8, 3'd1, 8'h7A);
    wait_ready("midreset");
    @(negedge clk);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL midreset_count got %0d exp 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'hFF || got_q[1] !== 8'h7A) begin
        errors++; $display("FAIL midreset_stream got %h %h exp FF 7A", got_q[0], got_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_literal();
    test_overlap();
    test_initial_copy();
    test_valid_ignored();
    test_end_marker();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
